pipe_reg_chain: RTL and testbench
=================================

// Module: pipe_reg_chain
// PURPOSE
//  Parametrised successor to the single 14-bit enable/reset-to-one register.
//  A chain of DEPTH WIDTH-bit pipeline registers with valid/ready flow control.
//  Bubbles collapse and backpressure stalls only the full stages.
//  Sits between NN datapath stages (MAC, activation, weight fetch) to retime
//  operands without losing or duplicating words under stall.
// PARAMETERS
//  WIDTH      14  data width of every stage, in bits
//  DEPTH      3   number of register stages (>=1); sets the no-stall latency
//  RESET_VAL  1   value loaded into every stage data register on reset/clear
// PORTS
//  Clk        in   1         clock; all state updates on rising edge
//  Rst        in   1         reset, asynchronous, active-low
//  clr        in   1         synchronous flush of all stages, active-high
//  in_valid   in   1         upstream word present on in_data
//  in_data    in   WIDTH     upstream word
//  in_ready   out  1         chain accepts in_data this cycle
//  out_valid  out  1         last stage holds a valid word
//  out_data   out  WIDTH     last-stage data register
//  out_ready  in   1         downstream accepts out_data this cycle
//  occupancy  out  CW        valid stages, CW=$clog2(DEPTH+1) [PIPE_REG_CNT_EN only]
// BEHAVIOUR
//  - State: per stage k (0..DEPTH-1, k=DEPTH-1 is the output), v[k] and d[k].
//  - Reset (Rst=0, async): all v[k]=0, all d[k]=RESET_VAL, occupancy=0.
//    Reset takes effect immediately, mid-transfer included; in-flight words are dropped.
//  - Advance (combinational):
//    - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
//    - adv[k] = !v[k] | adv[k+1].
//  - in_ready = adv[0] & !clr. Push = in_valid & in_ready. Pop = out_valid & out_ready.
//  - On clock, for each k with adv[k]:
//    - k=0: v[0] <= in_valid & !clr, and d[0] <= in_data only if in_valid.
//    - k>0: v[k] <= v[k-1], and d[k] <= d[k-1] only if v[k-1].
//  - For each k without adv[k]: v[k] and d[k] hold.
//  - An emptied stage keeps its old d[k]; out_data is meaningful only when out_valid=1.
//  - Latency: a word pushed in cycle n appears on out_valid at cycle n+DEPTH if no stall.
//    Throughput is 1 word/cycle.
//  - Full chain (all v=1):
//    - out_ready=0: in_ready=0 and everything holds.
//    - out_ready=1: pop and push occur in the same cycle; the chain stays full.
//  - Bubble collapse: a word advances into any empty stage even while the output is stalled.
//  - clr=1 (sync): next edge sets all v=0 and all d=RESET_VAL. clr has priority over push/pop.
//    - in_ready=0 during clr; an in_valid word is not accepted.
//    - out_valid and out_data still reflect current state during the clr cycle;
//      a pop seen in that cycle counts as delivered.
//  - in_data is passed bit-exact; no arithmetic or width change.
//  - Inputs are sampled only at the edge; no combinational path from in_data to out_data.
// CONFIGURATION
//  PIPE_REG_CNT_EN defined:
//    - occupancy port present: registered count of v[k]=1.
//    - Per edge: +1 on push only, -1 on pop only, unchanged on both or neither; 0 on reset/clr.
//    - Range 0..DEPTH; must equal the popcount of v after every edge.
//  PIPE_REG_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING  (WIDTH=14, DEPTH=3, RESET_VAL=1)
//  1 Rst low mid-stream with 2 words in flight -> out_valid=0, out_data=1 immediately, before the next edge; occupancy=0.
//  2 push 10,11,12 on consecutive cycles, out_ready=1 -> out 10,11,12 at push cycle+3; no gaps.
//  3 out_ready=0, push 4 words 20..23 -> in_ready=0 after 3rd push; 23 held upstream, occupancy=3;
//    release -> 20,21,22,23 in order, no loss or duplication.
//  4 out_ready=0; push 30, idle 1 cycle, push 31 -> words compress into stages 2 and 1; in_ready stays 1; occupancy=2.
//  5 full chain, clr=1 with in_valid=1, in_data=40 -> in_ready=0; next cycle out_valid=0, out_data=1, occupancy=0; 40 not accepted.
//  6 full chain, out_ready=1, in_valid=1 every cycle for 5 cycles -> in_ready=1 throughout, occupancy stays 3, 1 word out per cycle.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Valid/ready pipeline of DEPTH WIDTH-bit registers; bubbles collapse, stalls hold only full stages.
// Optional occupancy counter enabled by defining PIPE_REG_CNT_EN.
module pipe_reg_chain #(
  parameter int unsigned          WIDTH     = 14,
  parameter int unsigned          DEPTH     = 3,
  parameter logic [WIDTH-1:0]     RESET_VAL = WIDTH'(1)
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          in_ready,
  output logic                          out_valid,
  output logic [WIDTH-1:0]              out_data,
`ifdef PIPE_REG_CNT_EN
  output logic [$clog2(DEPTH+1)-1:0]    occupancy,
`endif
  input  logic                          out_ready
);

  logic [DEPTH-1:0]            v;
  logic [DEPTH-1:0]            v_nxt;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0][WIDTH-1:0] d;
  logic [DEPTH-1:0][WIDTH-1:0] d_nxt;

  // A stage may advance unless it and every stage downstream of it are full and stalled.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign adv[k] = ~(&v[DEPTH-1:k]) | out_ready;
    if (k == 0) begin : g_head
      assign v_nxt[k] = adv[k] ? in_valid : v[k];
      assign d_nxt[k] = (adv[k] && in_valid) ? in_data : d[k];
    end else begin : g_body
      assign v_nxt[k] = adv[k] ? v[k-1] : v[k];
      assign d_nxt[k] = (adv[k] && v[k-1]) ? d[k-1] : d[k];
    end
  end

  assign in_ready  = adv[0] & ~clr;
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Stage registers; clear wins over any transfer in the same cycle.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      v <= '0;
      d <= {DEPTH{RESET_VAL}};
    end else if (clr) begin
      v <= '0;
      d <= {DEPTH{RESET_VAL}};
    end else begin
      v <= v_nxt;
      d <= d_nxt;
    end
  end

`ifdef PIPE_REG_CNT_EN
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic push;
  logic pop;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Tracks the number of valid stages; simultaneous push and pop cancel.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      occupancy <= '0;
    end else if (clr) begin
      occupancy <= '0;
    end else if (push && !pop) begin
      occupancy <= occupancy + CW'(1);
    end else if (pop && !push) begin
      occupancy <= occupancy - CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (WIDTH=14, DEPTH=3, RESET_VAL=1).
module tb_pipe_reg_chain;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        clr;
  logic        in_valid;
  logic [13:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [13:0] out_data;
  logic        out_ready;
`ifdef PIPE_REG_CNT_EN
  logic [1:0]  occupancy;
`endif

  typedef struct {
    logic [13:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   n_pop   = 0;
  bit   chk_lat = 1'b0;

  pipe_reg_chain dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef PIPE_REG_CNT_EN
    .occupancy (occupancy),
`endif
    .out_ready (out_ready)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [13:0] id, input logic ordy, input logic c);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    clr       = c;
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0 && !out_valid) break;
      step(1'b0, 14'd0, 1'b1, 1'b0);
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Negedge monitor: inputs and state are stable between edges.
  always @(negedge Clk) begin
    exp_t e;
    if (Rst) begin
      cyc++;
`ifdef PIPE_REG_CNT_EN
      check("occ_model", 32'(occupancy), 32'(q.size()));
`endif
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("out_data", 32'(out_data), 32'(e.data));
          if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd3);
          n_pop++;
        end
      end
      if (in_valid && in_ready) q.push_back('{in_data, cyc});
      if (clr) begin
        check("clr_in_ready", 32'(in_ready), 32'd0);
        q.delete();
      end
    end
  end

  initial begin
    int p0;
    Rst = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    @(posedge Clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd1);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPE_REG_CNT_EN
    check("rst_occ", 32'(occupancy), 32'd0);
`endif
    @(posedge Clk);
    #1 Rst = 1'b1;

    // 1: async reset mid-stream with two words in flight
    step(1'b1, 14'd50, 1'b0, 1'b0);
    step(1'b1, 14'd51, 1'b0, 1'b0);
    step(1'b0, 14'd0, 1'b0, 1'b0);
    check("t1_pre_valid", 32'(out_valid), 32'd1);
    check("t1_pre_data", 32'(out_data), 32'd50);
    #2 Rst = 1'b0;
    q.delete();
    #1;
    check("t1_out_valid", 32'(out_valid), 32'd0);
    check("t1_out_data", 32'(out_data), 32'd1);
`ifdef PIPE_REG_CNT_EN
    check("t1_occ", 32'(occupancy), 32'd0);
`endif
    @(posedge Clk);
    #1 Rst = 1'b1;

    // 2: streaming, latency 3 with no gaps
    chk_lat = 1'b1;
    p0 = n_pop;
    for (int i = 0; i < 3; i++) step(1'b1, 14'(10 + i), 1'b1, 1'b0);
    drain();
    check("t2_pops", 32'(n_pop - p0), 32'd3);
    chk_lat = 1'b0;

    // 3: stall with four offered words; the fourth waits upstream
    p0 = n_pop;
    for (int i = 0; i < 3; i++) step(1'b1, 14'(20 + i), 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 14'd23; #1;
    check("t3_in_ready", 32'(in_ready), 32'd0);
`ifdef PIPE_REG_CNT_EN
    check("t3_occ", 32'(occupancy), 32'd3);
`endif
    step(1'b1, 14'd23, 1'b0, 1'b0);
    check("t3_in_ready_hold", 32'(in_ready), 32'd0);
    check("t3_hold_data", 32'(out_data), 32'd20);
    step(1'b1, 14'd23, 1'b1, 1'b0);
    drain();
    check("t3_pops", 32'(n_pop - p0), 32'd4);

    // 4: bubble collapse under output stall
    step(1'b1, 14'd30, 1'b0, 1'b0);
    check("t4_in_ready_a", 32'(in_ready), 32'd1);
    step(1'b0, 14'd0, 1'b0, 1'b0);
    check("t4_in_ready_b", 32'(in_ready), 32'd1);
    step(1'b1, 14'd31, 1'b0, 1'b0);
    check("t4_in_ready_c", 32'(in_ready), 32'd1);
    step(1'b0, 14'd0, 1'b0, 1'b0);
    check("t4_in_ready_d", 32'(in_ready), 32'd1);
    check("t4_out_valid", 32'(out_valid), 32'd1);
    check("t4_out_data", 32'(out_data), 32'd30);
`ifdef PIPE_REG_CNT_EN
    check("t4_occ", 32'(occupancy), 32'd2);
`endif

    // 5: clear a full chain while a word is offered
    step(1'b1, 14'd32, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 14'd40; out_ready = 1'b0; clr = 1'b1; #1;
    check("t5_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 14'd40, 1'b0, 1'b1);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_out_data", 32'(out_data), 32'd1);
`ifdef PIPE_REG_CNT_EN
    check("t5_occ", 32'(occupancy), 32'd0);
`endif
    for (int i = 0; i < 4; i++) step(1'b0, 14'd0, 1'b1, 1'b0);
    check("t5_not_accepted", 32'(out_valid), 32'd0);

    // 6: full chain streaming at one word per cycle
    for (int i = 0; i < 3; i++) step(1'b1, 14'(60 + i), 1'b0, 1'b0);
    p0 = n_pop;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = 14'(70 + i); out_ready = 1'b1; clr = 1'b0; #1;
      check("t6_in_ready", 32'(in_ready), 32'd1);
      check("t6_out_valid", 32'(out_valid), 32'd1);
`ifdef PIPE_REG_CNT_EN
      check("t6_occ", 32'(occupancy), 32'd3);
`endif
      @(posedge Clk);
      #1;
    end
    check("t6_pops", 32'(n_pop - p0), 32'd5);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
